shift_reg_seq: RTL and testbench
================================

Name: shift_reg_seq

Overview:
- Parametrised WIDTH-bit shift register with four shift modes, parallel load and a single-step shift.
- Adds a sequenced multi-bit shift engine: `start` plus `amount` runs N one-bit shifts, one per cycle, with a busy/done handshake.
- It is the general shifter for the Hack-on-FPGA datapath and I/O serialisers. With mode LSR, single-step `shift` and `ser_in` as the inserted MSB, it reproduces the earlier fixed-width right shifter.

Parameters:
- WIDTH, 16, register width in bits (>=2).
- RESET_VAL, 0, value of `out` after reset.
- AMT_W, $clog2(WIDTH)+1 (localparam), width of `amount`; holds values up to WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-high.
- in  in  WIDTH  parallel load data.
- load  in  1  parallel load strobe.
- shift  in  1  single-step shift strobe, honoured in IDLE/DONE only.
- start  in  1  begin multi-bit shift, honoured in IDLE/DONE only.
- amount  in  AMT_W  shift count, sampled with `start`.
- mode  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR; sampled by `shift`, or latched at `start`.
- ser_in  in  1  bit inserted by LSL (at LSB) and LSR (at MSB); sampled live on every shift edge.
- out  out  WIDTH  register contents.
- ser_out  out  1  bit discarded or rotated out by the most recent shift.
- busy  out  1  high while the engine is in RUN.
- done  out  1  one-cycle pulse when a `start` operation completes.

Behaviour:
- Reset (synchronous, highest priority):
  - out=RESET_VAL, ser_out=0, busy=0, done=0, state=IDLE.
  - Any run in progress is dropped with no done pulse.
- Step functions for WIDTH=W:
  - LSL: {out[W-2:0], ser_in}; ser_out<=out[W-1].
  - LSR: {ser_in, out[W-1:1]}; ser_out<=out[0].
  - ASR: {out[W-1], out[W-1:1]}; ser_out<=out[0].
  - ROR: {out[0], out[W-1:1]}; ser_out<=out[0].
- State machine: IDLE, RUN, DONE.
  - busy = (state==RUN); done = (state==DONE).
- Priority per edge: reset > load > start > shift.
- load, in any state: out<=in; state<=IDLE.
  - A load during RUN aborts the run: busy falls on the same edge and no done pulse occurs. ser_out is unchanged.
- start in IDLE/DONE:
  - Latch mode.
  - N = min(amount, WIDTH); counter<=N.
  - N>0: state<=RUN, no shift on this edge.
  - N==0: state<=DONE, out unchanged.
- RUN:
  - Each edge applies one step using the latched mode; counter decrements.
  - When counter==1 at the edge: state<=DONE.
  - start, shift and mode changes are ignored during RUN.
- DONE: returns to IDLE on the next edge unless start/load/shift acts. A start there is accepted, so back-to-back runs are allowed.
- shift in IDLE/DONE: one step using the live mode; state<=IDLE.
- Latency: start sampled at edge k with N>0:
  - Shifts occur at edges k+1..k+N.
  - busy is high from after edge k through edge k+N.
  - done is high for the single cycle after edge k+N.
  - Total N+1 cycles from start to done.
- Clamp: amount > WIDTH is treated as WIDTH. ROR by WIDTH returns the original value after WIDTH cycles.
- No-strobe edges: out and ser_out hold.

Decomposition:
- Package shift_pkg:
  - mode constants MODE_LSL/LSR/ASR/ROR (2-bit).
  - state encodings ST_IDLE/ST_RUN/ST_DONE.
- One combinational sub-module, shift_step: inputs (value, mode, ser_in), outputs (next value, out bit). It is instantiated once and shared by the single-step and RUN paths.
- Counter, FSM and register stay in shift_reg_seq.

Test Plan:
- WIDTH=16; load 0x0002; idle shift mode=01 ser_in=1 -> out=0x8001, ser_out=0, busy stays 0, no done.
- load 0x8000; start mode=10 amount=4 -> busy high 4 cycles, out steps 0xC000, 0xE000, 0xF000, 0xF800; done pulses once on cycle 5.
- load 0x0001; start mode=11 amount=16 -> 16 busy cycles, final out=0x0001; amount=20 mode=00 ser_in=0 on 0x00FF -> clamps to 16 cycles, out=0x0000.
- start amount=0 -> out unchanged, busy never rises, done high the next cycle; start asserted while done is high -> accepted.
- load 0x00F0; start mode=00 amount=8; on busy cycle 3 pulse load 0x1234 -> out=0x1234, busy falls that edge, no done pulse; shift/start/mode toggled during RUN have no effect.
- Mid-run reset during an 8-step LSR run -> next cycle out=RESET_VAL, busy=0, done=0, ser_out=0; a following start runs normally.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared constants for the sequenced shift register: shift-mode codes and FSM states.
// Pure declarations; no logic, no latency.
// Imported by shift_step and shift_reg_seq.
package shift_pkg;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One-bit shift step for all four modes; purely combinational.
// Zero latency; no handshake, the caller decides when to register the result.
// Shared by the single-step and multi-step paths of shift_reg_seq.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  output logic [WIDTH-1:0] next_value,
  output logic             out_bit
);

  // Select the shifted value and the bit that falls off the end
  always_comb begin
    next_value = value;
    out_bit    = value[0];
    case (mode)
      MODE_LSL: begin
        next_value = {value[WIDTH-2:0], ser_in};
        out_bit    = value[WIDTH-1];
      end
      MODE_LSR: begin
        next_value = {ser_in, value[WIDTH-1:1]};
        out_bit    = value[0];
      end
      MODE_ASR: begin
        next_value = {value[WIDTH-1], value[WIDTH-1:1]};
        out_bit    = value[0];
      end
      default: begin
        next_value = {value[0], value[WIDTH-1:1]};
        out_bit    = value[0];
      end
    endcase
  end

endmodule

// File: rtl/shift_reg_seq.sv
// WIDTH-bit shift register with parallel load, single-step shift and an N-step shift engine.
// Single step / load take effect on the next edge; a start of N>0 shifts on the next N edges, done one cycle later.
// No backpressure: start/shift are ignored while busy; load aborts a run at any time.
module shift_reg_seq
  import shift_pkg::*;
#(
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int             AMT_W     = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             shift,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  output logic [WIDTH-1:0] out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [1:0]       mode_q;
  logic [AMT_W-1:0] count;
  logic [AMT_W-1:0] amt_clamped;
  logic [1:0]       step_mode;
  logic [WIDTH-1:0] step_value;
  logic             step_bit;

  // Runs use the mode captured at start; single steps use the live mode
  always_comb begin
    step_mode   = (state == ST_RUN) ? mode_q : mode;
    amt_clamped = (amount > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amount;
  end

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .value     (out),
    .mode      (step_mode),
    .ser_in    (ser_in),
    .next_value(step_value),
    .out_bit   (step_bit)
  );

  // Register, counter and FSM; priority reset > load > run/start > shift
  always_ff @(posedge clk) begin
    if (reset) begin
      out     <= RESET_VAL;
      ser_out <= 1'b0;
      state   <= ST_IDLE;
      mode_q  <= MODE_LSL;
      count   <= '0;
    end else if (load) begin
      // Aborts any run; ser_out keeps the bit from the last real shift
      out   <= in;
      state <= ST_IDLE;
    end else if (state == ST_RUN) begin
      out     <= step_value;
      ser_out <= step_bit;
      count   <= count - 1'b1;
      if (count == AMT_W'(1)) begin
        state <= ST_DONE;
      end
    end else if (start) begin
      mode_q <= mode;
      count  <= amt_clamped;
      state  <= (amt_clamped == '0) ? ST_DONE : ST_RUN;
    end else if (shift) begin
      out     <= step_value;
      ser_out <= step_bit;
      state   <= ST_IDLE;
    end else begin
      state <= ST_IDLE;
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_shift_reg_seq.sv
// Self-checking bench for shift_reg_seq (WIDTH=16, non-zero reset value).
// Every cycle the reference model's expected outputs are queued and compared after the edge.
// Directed test-plan values are also checked against literal constants.
module tb_shift_reg_seq;

  localparam int         W  = 16;
  localparam int         AW = $clog2(W) + 1;
  localparam logic [W-1:0] RV = 16'hA5A5;

  logic          clk = 1'b0;
  logic          reset, load, shift, start, ser_in;
  logic [W-1:0]  in_d;
  logic [AW-1:0] amount;
  logic [1:0]    mode;
  logic [W-1:0]  out;
  logic          ser_out, busy, done;

  shift_reg_seq #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .in(in_d), .load(load), .shift(shift),
    .start(start), .amount(amount), .mode(mode), .ser_in(ser_in),
    .out(out), .ser_out(ser_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] o;
    logic         s;
    logic         b;
    logic         d;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   busy_cycles;
  int   done_cycles;

  // reference model state
  logic [W-1:0] m_out;
  logic         m_ser;
  int           m_st;   // 0 idle, 1 run, 2 done
  int           m_cnt;
  logic [1:0]   m_mode;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_step(input logic [W-1:0] v, input logic [1:0] md,
                                   input logic si, output logic [W-1:0] nv, output logic bo);
    case (md)
      2'd0: begin nv = (v << 1) | W'(si);              bo = v[W-1]; end
      2'd1: begin nv = (v >> 1) | (W'(si) << (W-1));   bo = v[0];   end
      2'd2: begin nv = W'($signed(v) >>> 1);            bo = v[0];   end
      default: begin nv = (v >> 1) | (W'(v[0]) << (W-1)); bo = v[0]; end
    endcase
  endfunction

  // Advance model, queue expectation, clock one edge, compare
  task automatic tick();
    exp_t e;
    int   n;
    if (reset) begin
      m_out = RV; m_ser = 1'b0; m_st = 0;
    end else if (load) begin
      m_out = in_d; m_st = 0;
    end else if (m_st == 1) begin
      ref_step(m_out, m_mode, ser_in, m_out, m_ser);
      m_cnt--;
      if (m_cnt == 0) m_st = 2;
    end else if (start) begin
      n      = (int'(amount) > W) ? W : int'(amount);
      m_mode = mode;
      m_cnt  = n;
      m_st   = (n == 0) ? 2 : 1;
    end else if (shift) begin
      ref_step(m_out, mode, ser_in, m_out, m_ser);
      m_st = 0;
    end else begin
      m_st = 0;
    end
    e.o = m_out; e.s = m_ser; e.b = (m_st == 1); e.d = (m_st == 2);
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("out", 32'(out), 32'(e.o));
    chk("ser_out", 32'(ser_out), 32'(e.s));
    chk("busy", 32'(busy), 32'(e.b));
    chk("done", 32'(done), 32'(e.d));
    if (busy) busy_cycles++;
    if (done) done_cycles++;
  endtask

  task automatic idle_inputs();
    reset = 0; load = 0; shift = 0; start = 0;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    idle_inputs(); load = 1; in_d = v; tick(); load = 0;
  endtask

  task automatic do_start(input logic [1:0] md, input int amt, input logic si);
    idle_inputs(); start = 1; mode = md; amount = AW'(amt); ser_in = si; tick(); start = 0;
  endtask

  logic [W-1:0] asr_exp [4];

  initial begin
    asr_exp[0] = 16'hC000; asr_exp[1] = 16'hE000;
    asr_exp[2] = 16'hF000; asr_exp[3] = 16'hF800;
    m_out = 'x; m_ser = 'x; m_st = 0; m_cnt = 0; m_mode = 0;
    idle_inputs(); in_d = 0; amount = 0; mode = 0; ser_in = 0;

    // reset state
    reset = 1; tick(); reset = 0;
    chk("rst_out", 32'(out), 32'(RV));
    chk("rst_ser", 32'(ser_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // idle single-step LSR with ser_in=1
    do_load(16'h0002);
    shift = 1; mode = 2'b01; ser_in = 1; tick(); shift = 0;
    chk("lsr_out", 32'(out), 32'h8001);
    chk("lsr_ser", 32'(ser_out), 32'd0);
    chk("lsr_busy", 32'(busy), 32'd0);
    chk("lsr_done", 32'(done), 32'd0);

    // ASR by 4
    do_load(16'h8000);
    do_start(2'b10, 4, 1'b0);
    chk("asr_busy0", 32'(busy), 32'd1);
    chk("asr_hold0", 32'(out), 32'h8000);
    busy_cycles = 0; done_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("asr_step", 32'(out), 32'(asr_exp[i]));
    end
    chk("asr_done", 32'(done), 32'd1);
    tick();
    chk("asr_busy_cnt", 32'(busy_cycles), 32'd3);
    chk("asr_done_cnt", 32'(done_cycles), 32'd1);

    // ROR by full width returns original
    do_load(16'h0001);
    do_start(2'b11, 16, 1'b0);
    busy_cycles = 1; done_cycles = 0;
    for (int i = 0; i < 16; i++) tick();
    chk("ror_out", 32'(out), 32'h0001);
    chk("ror_busy_cnt", 32'(busy_cycles), 32'd16);
    chk("ror_done", 32'(done), 32'd1);

    // amount clamp: 20 -> 16
    do_load(16'h00FF);
    do_start(2'b00, 20, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    chk("clamp_busy", 32'(busy), 32'd1);
    tick();
    chk("clamp_out", 32'(out), 32'h0000);
    chk("clamp_done", 32'(done), 32'd1);

    // amount 0, then start accepted while done is high
    do_load(16'h1357);
    do_start(2'b01, 0, 1'b0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_out", 32'(out), 32'h1357);
    do_start(2'b01, 2, 1'b0);
    chk("b2b_busy", 32'(busy), 32'd1);
    tick(); tick();
    chk("b2b_out", 32'(out), 32'h04D5);
    chk("b2b_done", 32'(done), 32'd1);

    // load aborts run; strobes during RUN ignored
    do_load(16'h00F0);
    do_start(2'b00, 8, 1'b0);
    shift = 1; start = 1; mode = 2'b11; amount = AW'(3); tick();
    chk("ign_out1", 32'(out), 32'h01E0);
    tick();
    chk("ign_out2", 32'(out), 32'h03C0);
    shift = 0; start = 0;
    do_load(16'h1234);
    chk("abort_out", 32'(out), 32'h1234);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    chk("abort_nodone", 32'(done), 32'd0);

    // mid-run reset, then a normal run
    do_load(16'hF00F);
    do_start(2'b01, 8, 1'b1);
    tick(); tick(); tick();
    reset = 1; tick(); reset = 0;
    chk("mrst_out", 32'(out), 32'(RV));
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_ser", 32'(ser_out), 32'd0);
    do_start(2'b01, 3, 1'b0);
    tick(); tick(); tick();
    chk("post_out", 32'(out), 32'h14B4);
    chk("post_done", 32'(done), 32'd1);

    // random traffic under the scoreboard
    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(0, 99) == 0);
      load   = ($urandom_range(0, 19) == 0);
      start  = ($urandom_range(0, 5) == 0);
      shift  = ($urandom_range(0, 2) == 0);
      mode   = 2'($urandom_range(0, 3));
      ser_in = 1'($urandom_range(0, 1));
      amount = AW'($urandom_range(0, 31));
      in_d   = W'($urandom);
      tick();
    end
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
